// File: rtl/l2_dmem_bank_ctrl.sv
// Request front-end for one single-port L2 data-memory bank: round-robin arbitration of two
// requesters onto the bank port, with a credit-protected response FIFO for read data.
module l2_dmem_bank_ctrl #(
  parameter int unsigned RspDepth = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            req_valid_i,
  output logic [1:0]            req_ready_o,
  input  logic [1:0]            req_we_i,
  input  logic [1:0][9:0]       req_addr_i,
  input  logic [1:0][255:0]     req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_id_o,
  output logic [255:0]          rsp_data_o,
  output logic                  ce_o,
  output logic                  we_o,
  output logic [9:0]            addr_o,
  output logic [255:0]          wr_data_o,
  input  logic [255:0]          rd_data_i
);

  localparam int unsigned OccW = $clog2(RspDepth + 1);
  localparam int unsigned PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam logic [OccW:0]   DepthW = (OccW + 1)'(RspDepth);
  localparam logic [OccW-1:0] FullW  = OccW'(RspDepth);

  typedef struct packed {
    logic         id;
    logic [255:0] data;
  } rsp_t;

  rsp_t            fifo_q [RspDepth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [OccW-1:0] occ_q, occ_d;
  logic            ptr_q;
  logic            inflight_q, inflight_id_q;

  logic            push, pop, credit, grant_any, gnt_idx;
  logic [1:0]      elig;
  logic [OccW:0]   pending;
  rsp_t            head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RspDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign push = inflight_q;
  assign pop  = rsp_valid_o & rsp_ready_i;

  // Slots committed once this cycle settles; a same-cycle pop frees one immediately.
  assign pending = {1'b0, occ_q} + {{OccW{1'b0}}, inflight_q} - {{OccW{1'b0}}, pop};
  assign credit  = (pending < DepthW);
  assign elig    = req_valid_i & (req_we_i | {2{credit}}) & {2{~rst_i}};

  always_comb begin
    grant_any = |elig;
    gnt_idx   = (elig == 2'b11) ? ptr_q : elig[1];
    req_ready_o = grant_any ? (2'b01 << gnt_idx) : 2'b00;
    ce_o      = grant_any;
    we_o      = grant_any & req_we_i[gnt_idx];
    addr_o    = grant_any ? req_addr_i[gnt_idx] : '0;
    wr_data_o = grant_any ? req_wdata_i[gnt_idx] : '0;
  end

  always_comb begin
    occ_d = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + OccW'(1);
    end else if (pop && !push) begin
      occ_d = occ_q - OccW'(1);
    end
  end

  assign head        = fifo_q[rd_ptr_q];
  assign rsp_valid_o = (occ_q != '0) & ~rst_i;
  assign rsp_id_o    = rsp_valid_o & head.id;
  assign rsp_data_o  = rsp_valid_o ? head.data : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q         <= 1'b0;
      occ_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      inflight_q    <= 1'b0;
      inflight_id_q <= 1'b0;
    end else begin
      if (grant_any) begin
        ptr_q <= ~gnt_idx;
      end
      inflight_q    <= grant_any & ~req_we_i[gnt_idx];
      inflight_id_q <= gnt_idx;
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      occ_q <= occ_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by occ_q.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      fifo_q[wr_ptr_q] <= '{id: inflight_id_q, data: rd_data_i};
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && !pop && occ_q == FullW));

endmodule

// File: tb/tb_l2_dmem_bank_ctrl.sv
// Bench for l2_dmem_bank_ctrl: directed per-cycle vector table, then a random mixed-traffic
// run against a reference memory and response scoreboard.
module tb_l2_dmem_bank_ctrl;

  localparam int unsigned RspDepth = 2;
  localparam logic [255:0] Z  = '0;
  localparam logic [255:0] D0 = {8{32'hA5A5_0001}};
  localparam logic [255:0] D1 = {8{32'h1111_2222}};
  localparam logic [255:0] D2 = {8{32'h3333_4444}};

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid, req_ready, req_we;
  logic [1:0][9:0]  req_addr;
  logic [1:0][255:0] req_wdata;
  logic             rsp_valid, rsp_ready, rsp_id;
  logic [255:0]     rsp_data;
  logic             ce, we;
  logic [9:0]       addr;
  logic [255:0]     wr_data, rd_data;

  always #5 clk = ~clk;

  l2_dmem_bank_ctrl #(.RspDepth(RspDepth)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_we_i   (req_we),
    .req_addr_i (req_addr),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_id_o   (rsp_id),
    .rsp_data_o (rsp_data),
    .ce_o       (ce),
    .we_o       (we),
    .addr_o     (addr),
    .wr_data_o  (wr_data),
    .rd_data_i  (rd_data)
  );

  // Behavioural single-port bank: write on CE&WE, read data registered on CE&!WE.
  logic [255:0] bank_mem [1024];
  always @(posedge clk) begin
    if (ce && we) bank_mem[addr] <= wr_data;
    if (ce && !we) rd_data <= bank_mem[addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [271:0] act, input logic [271:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         rst;
    logic [1:0]   vld, we;
    logic [9:0]   a0, a1;
    logic [255:0] w0, w1;
    logic         rdy;
    logic [1:0]   e_rdy;
    logic         e_ce, e_we;
    logic [9:0]   e_addr;
    logic [255:0] e_wd;
    logic         e_rv, e_rid;
    logic [255:0] e_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst_v, input logic [1:0] vld, input logic [1:0] wev,
                     input logic [9:0] a0, input logic [9:0] a1,
                     input logic [255:0] w0, input logic [255:0] w1, input logic rdy,
                     input logic [1:0] e_rdy, input logic e_ce, input logic e_we,
                     input logic [9:0] e_addr, input logic [255:0] e_wd,
                     input logic e_rv, input logic e_rid, input logic [255:0] e_rd);
    vec_t v;
    v.rst = rst_v; v.vld = vld; v.we = wev; v.a0 = a0; v.a1 = a1; v.w0 = w0; v.w1 = w1;
    v.rdy = rdy; v.e_rdy = e_rdy; v.e_ce = e_ce; v.e_we = e_we; v.e_addr = e_addr;
    v.e_wd = e_wd; v.e_rv = e_rv; v.e_rid = e_rid; v.e_rd = e_rd;
    vecs.push_back(v);
  endtask

  typedef struct packed {
    logic         id;
    logic [255:0] d;
  } exp_t;

  exp_t         expq[$];
  logic [255:0] ref_mem [1024];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    cyc, acc, nrd, max_out;
    logic  g;
    logic [1:0] drop;
    exp_t  e;

    for (int i = 0; i < 1024; i++) bank_mem[i] = '0;
    rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;

    // Reset, write-then-read, round-robin, backpressure, read-after-write, reset mid-flight.
    add(1, 2'b11, 2'b11, 10'h155, 10'h010, D0, D1, 1, 2'b00, 0, 0, 10'h000, Z, 0, 0, Z);
    add(1, 2'b00, 2'b00, 10'h000, 10'h000, Z,  Z,  1, 2'b00, 0, 0, 10'h000, Z, 0, 0, Z);
    add(0, 2'b01, 2'b01, 10'h155, 10'h000, D0, Z,  1, 2'b01, 1, 1, 10'h155, D0, 0, 0, Z);
    add(0, 2'b01, 2'b00, 10'h155, 10'h000, Z,  Z,  1, 2'b01, 1, 0, 10'h155, Z, 0, 0, Z);
    add(0, 2'b10, 2'b10, 10'h000, 10'h010, Z,  D1, 1, 2'b10, 1, 1, 10'h010, D1, 0, 0, Z);
    add(0, 2'b00, 2'b00, 10'h000, 10'h000, Z,  Z,  1, 2'b00, 0, 0, 10'h000, Z, 1, 0, D0);
    add(1, 2'b00, 2'b00, 10'h000, 10'h000, Z,  Z,  1, 2'b00, 0, 0, 10'h000, Z, 0, 0, Z);
    add(0, 2'b11, 2'b00, 10'h155, 10'h010, Z,  Z,  1, 2'b01, 1, 0, 10'h155, Z, 0, 0, Z);
    add(0, 2'b11, 2'b00, 10'h155, 10'h010, Z,  Z,  1, 2'b10, 1, 0, 10'h010, Z, 0, 0, Z);
    add(0, 2'b11, 2'b00, 10'h155, 10'h010, Z,  Z,  1, 2'b01, 1, 0, 10'h155, Z, 1, 0, D0);
    add(0, 2'b11, 2'b00, 10'h155, 10'h010, Z,  Z,  1, 2'b10, 1, 0, 10'h010, Z, 1, 1, D1);
    add(0, 2'b00, 2'b00, 10'h000, 10'h000, Z,  Z,  1, 2'b00, 0, 0, 10'h000, Z, 1, 0, D0);
    add(0, 2'b00, 2'b00, 10'h000, 10'h000, Z,  Z,  1, 2'b00, 0, 0, 10'h000, Z, 1, 1, D1);
    add(0, 2'b10, 2'b00, 10'h000, 10'h010, Z,  Z,  0, 2'b10, 1, 0, 10'h010, Z, 0, 0, Z);
    add(0, 2'b10, 2'b00, 10'h000, 10'h155, Z,  Z,  0, 2'b10, 1, 0, 10'h155, Z, 0, 0, Z);
    add(0, 2'b11, 2'b01, 10'h020, 10'h155, D2, Z,  0, 2'b01, 1, 1, 10'h020, D2, 1, 1, D1);
    add(0, 2'b10, 2'b00, 10'h000, 10'h155, Z,  Z,  0, 2'b00, 0, 0, 10'h000, Z, 1, 1, D1);
    add(0, 2'b10, 2'b00, 10'h000, 10'h155, Z,  Z,  1, 2'b10, 1, 0, 10'h155, Z, 1, 1, D1);
    add(0, 2'b00, 2'b00, 10'h000, 10'h000, Z,  Z,  1, 2'b00, 0, 0, 10'h000, Z, 1, 1, D0);
    add(0, 2'b00, 2'b00, 10'h000, 10'h000, Z,  Z,  1, 2'b00, 0, 0, 10'h000, Z, 1, 1, D0);
    add(0, 2'b01, 2'b00, 10'h020, 10'h000, Z,  Z,  1, 2'b01, 1, 0, 10'h020, Z, 0, 0, Z);
    add(0, 2'b00, 2'b00, 10'h000, 10'h000, Z,  Z,  1, 2'b00, 0, 0, 10'h000, Z, 0, 0, Z);
    add(0, 2'b00, 2'b00, 10'h000, 10'h000, Z,  Z,  1, 2'b00, 0, 0, 10'h000, Z, 1, 0, D2);
    add(0, 2'b00, 2'b00, 10'h000, 10'h000, Z,  Z,  1, 2'b00, 0, 0, 10'h000, Z, 0, 0, Z);
    add(0, 2'b10, 2'b00, 10'h000, 10'h010, Z,  Z,  1, 2'b10, 1, 0, 10'h010, Z, 0, 0, Z);
    add(1, 2'b00, 2'b00, 10'h000, 10'h000, Z,  Z,  1, 2'b00, 0, 0, 10'h000, Z, 0, 0, Z);
    add(0, 2'b00, 2'b00, 10'h000, 10'h000, Z,  Z,  1, 2'b00, 0, 0, 10'h000, Z, 0, 0, Z);
    add(0, 2'b00, 2'b00, 10'h000, 10'h000, Z,  Z,  1, 2'b00, 0, 0, 10'h000, Z, 0, 0, Z);
    add(0, 2'b01, 2'b00, 10'h155, 10'h000, Z,  Z,  1, 2'b01, 1, 0, 10'h155, Z, 0, 0, Z);
    add(0, 2'b00, 2'b00, 10'h000, 10'h000, Z,  Z,  1, 2'b00, 0, 0, 10'h000, Z, 0, 0, Z);
    add(0, 2'b00, 2'b00, 10'h000, 10'h000, Z,  Z,  1, 2'b00, 0, 0, 10'h000, Z, 1, 0, D0);
    add(0, 2'b00, 2'b00, 10'h000, 10'h000, Z,  Z,  1, 2'b00, 0, 0, 10'h000, Z, 0, 0, Z);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; req_valid = vecs[i].vld; req_we = vecs[i].we;
      req_addr[0] = vecs[i].a0; req_addr[1] = vecs[i].a1;
      req_wdata[0] = vecs[i].w0; req_wdata[1] = vecs[i].w1; rsp_ready = vecs[i].rdy;
      #1;
      check($sformatf("v%0d req_ready", i), req_ready, vecs[i].e_rdy);
      check($sformatf("v%0d ce", i), ce, vecs[i].e_ce);
      check($sformatf("v%0d we", i), we, vecs[i].e_we);
      check($sformatf("v%0d addr", i), addr, vecs[i].e_addr);
      check($sformatf("v%0d wr_data", i), wr_data, vecs[i].e_wd);
      check($sformatf("v%0d rsp_valid", i), rsp_valid, vecs[i].e_rv);
      check($sformatf("v%0d rsp_id", i), rsp_id, vecs[i].e_rid);
      check($sformatf("v%0d rsp_data", i), rsp_data, vecs[i].e_rd);
    end

    // Random phase: reference memory holds what the directed phase wrote.
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    ref_mem[10'h155] = D0; ref_mem[10'h010] = D1; ref_mem[10'h020] = D2;
    @(negedge clk);
    rst = 1'b1; req_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    cyc = 0; acc = 0; nrd = 0; max_out = 0; drop = '0;
    while ((acc < 1000 || (req_valid & ~drop) != 2'b00) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      req_valid = req_valid & ~drop;
      drop = '0;
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i] && acc < 1000 && $urandom_range(0, 3) != 0) begin
          req_valid[i] = 1'b1;
          req_we[i]    = 1'($urandom_range(0, 1));
          req_addr[i]  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                                      : 10'($urandom_range(0, 15));
          for (int k = 0; k < 8; k++) req_wdata[i][k*32 +: 32] = $urandom;
        end
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      #1;
      check("rnd ready legal", {req_ready & ~req_valid, $onehot0(req_ready)}, {2'b00, 1'b1});
      check("rnd ce", ce, |req_ready);
      if ((req_valid & req_we) != 2'b00) check("rnd write progress", |req_ready, 1'b1);
      if (rsp_valid && rsp_ready) begin
        if (expq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rnd spurious response: got id %0d data %h, expected none",
                   rsp_id, rsp_data);
        end else begin
          e = expq.pop_front();
          check("rnd rsp", {rsp_id, rsp_data}, {e.id, e.d});
        end
      end
      if (|req_ready) begin
        g = req_ready[1];
        check("rnd bank port", {we, addr, wr_data}, {req_we[g], req_addr[g], req_wdata[g]});
        if (req_we[g]) begin
          ref_mem[req_addr[g]] = req_wdata[g];
        end else begin
          expq.push_back({g, ref_mem[req_addr[g]]});
          nrd++;
        end
        acc++;
        drop[g] = 1'b1;
      end
      if (expq.size() > max_out) max_out = expq.size();
    end
    check("rnd cycle budget", cyc < 20000, 1'b1);
    check("rnd max outstanding reads", max_out <= RspDepth, 1'b1);
    check("rnd reads issued", nrd > 200, 1'b1);

    @(negedge clk);
    req_valid = '0; rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (rsp_valid) begin
        if (expq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL drain spurious response: got id %0d data %h, expected none",
                   rsp_id, rsp_data);
        end else begin
          e = expq.pop_front();
          check("drain rsp", {rsp_id, rsp_data}, {e.id, e.d});
        end
      end
      @(negedge clk);
    end
    check("drain all responses returned", expq.size(), 0);
    check("drain rsp_valid idle", rsp_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
